// File: rtl/vec_seq_pkg.sv
// Shared types and default sizing for the exhaustive vector sequencer.
package vec_seq_pkg;

    typedef enum logic [2:0] {
        IDLE, DUT_RST, APPLY, SETTLE, CAPTURE, EMIT, DONE
    } seq_state_e;

    localparam int N_IN_DEF    = 6;
    localparam int N_OUT_DEF   = 1;
    localparam int SETTLE_DEF  = 2;
    localparam int RST_CYC_DEF = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/exhaustive_vector_sequencer_if.sv
// Record stream from the sequencer to the result logger (valid/ready).
interface exhaustive_vector_sequencer_if import vec_seq_pkg::*; #(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF
);
    logic             rec_valid;
    logic             rec_ready;
    logic [N_IN-1:0]  rec_vec;
    logic [N_OUT-1:0] rec_resp;
    logic             rec_last;

    modport master (output rec_valid, rec_vec, rec_resp, rec_last, input rec_ready);
    modport slave  (input rec_valid, rec_vec, rec_resp, rec_last, output rec_ready);
endinterface

// File: rtl/vec_seq_timer.sv
// Loadable down-counter with zero flag; times both the DUT reset and settle waits.
module vec_seq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   cnt <= '0;
        else if (load)                cnt <= load_val;
        else if (dec && cnt != '0)    cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/exhaustive_vector_sequencer.sv
// Walks every N_IN-bit input pattern through a DUT, waits SETTLE cycles, and
// streams one {vector, response} record per pattern to the logger.
module exhaustive_vector_sequencer import vec_seq_pkg::*; #(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int SETTLE  = SETTLE_DEF,
    parameter int RST_CYC = RST_CYC_DEF
) (
    input  logic                  CK,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  dut_rst,
    output logic [N_IN-1:0]       dut_in,
    input  logic [N_OUT-1:0]      dut_out,
    exhaustive_vector_sequencer_if.master rec
);
    localparam int TW = $clog2(max2(SETTLE, RST_CYC) + 1);
    localparam logic [N_IN:0] LAST_VEC = (N_IN+1)'((1 << N_IN) - 1);

    seq_state_e    state, state_d;
    logic [N_IN:0] vec_cnt;
    logic          tmr_load, tmr_zero, tmr_dec;
    logic [TW-1:0] tmr_val;
    logic          hs, last_hs_q;

    assign hs      = rec.rec_valid && rec.rec_ready;
    assign busy    = (state != IDLE) && (state != DONE);
    assign dut_rst = (state == IDLE) || (state == DUT_RST);
    assign tmr_dec = (state == DUT_RST) || (state == vec_seq_pkg::SETTLE);

    vec_seq_timer #(.W(TW)) u_timer (
        .clk      (CK),
        .rst_n    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Timer loads N-1 so that the wait state lasts exactly N cycles.
    always_comb begin
        state_d  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE, DONE: if (start) begin
                state_d  = DUT_RST;
                tmr_load = 1'b1;
                tmr_val  = TW'(RST_CYC - 1);
            end
            DUT_RST: if (tmr_zero) state_d = APPLY;
            APPLY: begin
                state_d  = vec_seq_pkg::SETTLE;
                tmr_load = 1'b1;
                tmr_val  = TW'(SETTLE - 1);
            end
            vec_seq_pkg::SETTLE: if (tmr_zero) state_d = CAPTURE;
            CAPTURE: state_d = EMIT;
            EMIT: if (hs) state_d = rec.rec_last ? DONE : APPLY;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d  = IDLE;
            tmr_load = 1'b0;
        end
    end

    // done trails the final handshake by one extra cycle; abort squashes it.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            vec_cnt       <= '0;
            dut_in        <= '0;
            rec.rec_valid <= 1'b0;
            rec.rec_vec   <= '0;
            rec.rec_resp  <= '0;
            rec.rec_last  <= 1'b0;
            last_hs_q     <= 1'b0;
            done          <= 1'b0;
        end else begin
            last_hs_q <= (state == EMIT) && hs && rec.rec_last && !abort;
            done      <= last_hs_q && !abort;
            if (abort) begin
                rec.rec_valid <= 1'b0;
                dut_in        <= '0;
            end else begin
                case (state)
                    IDLE, DONE: if (start) vec_cnt <= '0;
                    DUT_RST: if (tmr_zero) dut_in <= vec_cnt[N_IN-1:0];
                    vec_seq_pkg::SETTLE: if (tmr_zero) begin
                        rec.rec_resp <= dut_out;
                        rec.rec_vec  <= vec_cnt[N_IN-1:0];
                        rec.rec_last <= (vec_cnt == LAST_VEC);
                    end
                    CAPTURE: rec.rec_valid <= 1'b1;
                    EMIT: if (hs) begin
                        rec.rec_valid <= 1'b0;
                        if (!rec.rec_last) begin
                            vec_cnt <= vec_cnt + 1'b1;
                            dut_in  <= N_IN'(vec_cnt + 1'b1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Directed bench: default build plus a small N_IN=2 build, parity DUT model.
module tb_exhaustive_vector_sequencer;
    logic CK = 1'b0;
    logic reset = 1'b0;
    always #5 CK = ~CK;

    logic       start_a = 1'b0, abort_a = 1'b0;
    logic       busy_a, done_a, dut_rst_a;
    logic [5:0] dut_in_a;
    logic [0:0] dut_out_a;
    exhaustive_vector_sequencer_if #(.N_IN(6), .N_OUT(1)) rec_a ();
    assign dut_out_a = ^dut_in_a;

    exhaustive_vector_sequencer u_a (
        .CK(CK), .reset(reset), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .dut_rst(dut_rst_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .rec(rec_a)
    );

    logic       start_b = 1'b0, abort_b = 1'b0;
    logic       busy_b, done_b, dut_rst_b;
    logic [1:0] dut_in_b;
    logic [0:0] dut_out_b;
    exhaustive_vector_sequencer_if #(.N_IN(2), .N_OUT(1)) rec_b ();
    assign dut_out_b = ^dut_in_b;

    exhaustive_vector_sequencer #(.N_IN(2), .N_OUT(1), .SETTLE(1), .RST_CYC(1)) u_b (
        .CK(CK), .reset(reset), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .dut_rst(dut_rst_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .rec(rec_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run of unit A; t counts edges after the start edge.
    task automatic run_a(input int pct, input bit spam, output int nrec, output int t_first,
                         output int t_done, output int n_bad, output int n_hold);
        int t = 0;
        bit stalled = 1'b0;
        logic [5:0] pv = '0;
        logic pr = 1'b0, pl = 1'b0;
        nrec = 0; t_first = -1; t_done = -1; n_bad = 0; n_hold = 0;
        start_a = 1'b1; step(); start_a = 1'b0;
        while (t < 8000 && t_done < 0) begin
            if (done_a) t_done = t;
            if (rec_a.rec_valid && t_first < 0) t_first = t;
            if (stalled && (!rec_a.rec_valid || rec_a.rec_vec !== pv ||
                            rec_a.rec_resp[0] !== pr || rec_a.rec_last !== pl)) n_hold++;
            if (rec_a.rec_valid && dut_in_a !== rec_a.rec_vec) n_hold++;
            rec_a.rec_ready = ($urandom_range(0, 99) < pct);
            if (rec_a.rec_valid && rec_a.rec_ready) begin
                if (rec_a.rec_vec !== nrec[5:0] || rec_a.rec_resp[0] !== ^nrec[5:0] ||
                    rec_a.rec_last !== (nrec == 63)) n_bad++;
                nrec++;
            end
            stalled = rec_a.rec_valid && !rec_a.rec_ready;
            pv = rec_a.rec_vec; pr = rec_a.rec_resp[0]; pl = rec_a.rec_last;
            start_a = spam && busy_a && (t % 7 == 3);
            step(); t++;
        end
        start_a = 1'b0;
        rec_a.rec_ready = 1'b1;
    endtask

    initial begin
        int nrec, tf, td, nb, nh, t, nd;
        rec_a.rec_ready = 1'b1;
        rec_b.rec_ready = 1'b1;
        #12;
        chk("rst_busy",     {31'b0, busy_a},          32'd0);
        chk("rst_done",     {31'b0, done_a},          32'd0);
        chk("rst_dut_rst",  {31'b0, dut_rst_a},       32'd1);
        chk("rst_dut_in",   {26'b0, dut_in_a},        32'd0);
        chk("rst_valid",    {31'b0, rec_a.rec_valid}, 32'd0);
        chk("rst_last",     {31'b0, rec_a.rec_last},  32'd0);
        #3 reset = 1'b1;
        step(); step();

        // 1) full run, ready tied high
        run_a(100, 1'b0, nrec, tf, td, nb, nh);
        chk("t1_records", nrec, 32'd64);
        chk("t1_payload", nb, 32'd0);
        chk("t1_hold", nh, 32'd0);
        chk("t1_first_valid", tf, 32'd6);
        chk("t1_done_at", td, 32'd323);
        step();
        chk("t1_done_pulse_1cyc", {31'b0, done_a}, 32'd0);
        chk("t1_busy_after", {31'b0, busy_a}, 32'd0);

        // 2) random backpressure
        run_a(30, 1'b0, nrec, tf, td, nb, nh);
        chk("t2_records", nrec, 32'd64);
        chk("t2_payload", nb, 32'd0);
        chk("t2_stall_hold", nh, 32'd0);
        chk("t2_done_seen", {31'b0, td > 0}, 32'd1);

        // 3) abort in EMIT of vector 17
        rec_a.rec_ready = 1'b1;
        start_a = 1'b1; step(); start_a = 1'b0;
        t = 0;
        while (t < 2000 && !(rec_a.rec_valid && rec_a.rec_vec == 6'd17)) begin step(); t++; end
        chk("t3_reached_v17", {31'b0, rec_a.rec_valid}, 32'd1);
        rec_a.rec_ready = 1'b0;
        abort_a = 1'b1; step(); abort_a = 1'b0;
        chk("t3_valid", {31'b0, rec_a.rec_valid}, 32'd0);
        chk("t3_dut_rst", {31'b0, dut_rst_a}, 32'd1);
        chk("t3_busy", {31'b0, busy_a}, 32'd0);
        nd = 0;
        for (int i = 0; i < 400; i++) begin
            if (done_a || busy_a) nd++;
            step();
        end
        chk("t3_no_done_no_busy", nd, 32'd0);
        rec_a.rec_ready = 1'b1;
        run_a(100, 1'b0, nrec, tf, td, nb, nh);
        chk("t3_replay_records", nrec, 32'd64);
        chk("t3_replay_payload", nb, 32'd0);

        // 4) start spam while busy, then restart from DONE
        run_a(100, 1'b1, nrec, tf, td, nb, nh);
        chk("t4_records", nrec, 32'd64);
        chk("t4_payload", nb, 32'd0);
        chk("t4_done_at", td, 32'd323);
        step();
        run_a(100, 1'b0, nrec, tf, td, nb, nh);
        chk("t4_rerun_records", nrec, 32'd64);
        chk("t4_rerun_done_at", td, 32'd323);

        // 5) async reset in the SETTLE wait of vector 5
        start_a = 1'b1; step(); start_a = 1'b0;
        t = 0;
        while (t < 2000 && !(rec_a.rec_valid && rec_a.rec_vec == 6'd4)) begin step(); t++; end
        step(); step();
        chk("t5_pre_dut_in", {26'b0, dut_in_a}, 32'd5);
        #2 reset = 1'b0;
        #1;
        chk("t5_busy", {31'b0, busy_a}, 32'd0);
        chk("t5_dut_rst", {31'b0, dut_rst_a}, 32'd1);
        chk("t5_dut_in", {26'b0, dut_in_a}, 32'd0);
        chk("t5_rec_vec", {26'b0, rec_a.rec_vec}, 32'd0);
        chk("t5_rec_resp", {31'b0, rec_a.rec_resp}, 32'd0);
        chk("t5_valid", {31'b0, rec_a.rec_valid}, 32'd0);
        #3 reset = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("t5_idle_busy", {31'b0, busy_a}, 32'd0);
        chk("t5_idle_dut_rst", {31'b0, dut_rst_a}, 32'd1);
        run_a(100, 1'b0, nrec, tf, td, nb, nh);
        chk("t5_rerun_records", nrec, 32'd64);
        chk("t5_rerun_payload", nb, 32'd0);

        // 6) small build: N_IN=2, SETTLE=1, RST_CYC=1
        start_b = 1'b1; step(); start_b = 1'b0;
        t = 0; nrec = 0; tf = -1; td = -1; nb = 0;
        while (t < 200 && td < 0) begin
            if (done_b) td = t;
            if (rec_b.rec_valid && tf < 0) tf = t;
            if (rec_b.rec_valid) begin
                if (rec_b.rec_vec !== nrec[1:0] || rec_b.rec_resp[0] !== ^nrec[1:0] ||
                    rec_b.rec_last !== (nrec == 3)) nb++;
                nrec++;
            end
            step(); t++;
        end
        chk("t6_records", nrec, 32'd4);
        chk("t6_payload", nb, 32'd0);
        chk("t6_first_valid", tf, 32'd4);
        chk("t6_done_at", td, 32'd18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
